// File: rtl/sfx_scheduler_if.sv
// rtl/sfx_scheduler_if.sv - shared sound-effect ROM port and DAC write channel
interface sfx_scheduler_if #(
  parameter int AW = 18
);
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_q;
  logic          aud_write_ready;
  logic          aud_write;
  logic [23:0]   aud_write_d;

  modport master (
    output rom_addr, aud_write, aud_write_d,
    input  rom_q, aud_write_ready
  );

  modport slave (
    input  rom_addr, aud_write, aud_write_d,
    output rom_q, aud_write_ready
  );
endinterface

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - fixed-priority preemptive sound-effect scheduler feeding one ROM and the DAC
// Optional attenuation (vol port, arithmetic shift of rom_q) when SFX_SCHED_ATTEN_EN is defined.
module sfx_scheduler #(
  parameter int             N    = 4,
  parameter int             AW   = 18,
  parameter logic [N*AW-1:0] BASE = '0,
  parameter logic [N*AW-1:0] LEN  = {N{AW'(48000)}}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N-1:0]                      trig,
`ifdef SFX_SCHED_ATTEN_EN
  input  logic [1:0]                        vol,
`endif
  sfx_scheduler_if.master                   bus,
  output logic                              busy,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] active_id
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] offset;
  logic [AW-1:0] rom_addr_r;
  logic [23:0]   sample;
  logic [23:0]   captured;
  logic [IW-1:0] winner;
  logic          accept;
  logic          last;
  logic          aud_write_c;

  always_comb begin
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (trig[i]) winner = IW'(i);
    end
  end

  // Equal id counts as a restart; lower-priority triggers lose while busy.
  assign accept = (|trig) && ((state == S_IDLE) || (winner >= active_id));
  assign last   = (offset == (LEN[int'(active_id)*AW +: AW] - AW'(1)));

`ifdef SFX_SCHED_ATTEN_EN
  assign captured = $signed(bus.rom_q) >>> vol;
`else
  assign captured = bus.rom_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = S_FETCH;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_FETCH: state_nxt = S_OUT;
        S_OUT:   if (bus.aud_write_ready) state_nxt = last ? S_IDLE : S_FETCH;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    aud_write_c = 1'b0;
    busy        = (state != S_IDLE);
    if ((state == S_IDLE) || (state == S_OUT)) aud_write_c = bus.aud_write_ready;
  end

  // A trigger mid-effect keeps the current sample so the DAC sees no glitch to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_id  <= '0;
      offset     <= '0;
      rom_addr_r <= '0;
      sample     <= '0;
    end else if (accept) begin
      active_id  <= winner;
      offset     <= '0;
      rom_addr_r <= BASE[int'(winner)*AW +: AW];
      if (state == S_IDLE) sample <= '0;
    end else begin
      case (state)
        S_FETCH: sample <= captured;
        S_OUT: begin
          if (bus.aud_write_ready) begin
            if (last) begin
              sample <= '0;
            end else begin
              offset     <= offset + AW'(1);
              rom_addr_r <= rom_addr_r + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr    = rom_addr_r;
  assign bus.aud_write   = aud_write_c;
  assign bus.aud_write_d = sample;
endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - directed vector bench for sfx_scheduler
module tb_sfx_scheduler;
  localparam int N  = 4;
  localparam int AW = 18;
  localparam logic [N*AW-1:0] BASE = {18'd1000, 18'd200, 18'd100, 18'd0};
  localparam logic [N*AW-1:0] LEN  = {18'd4, 18'd3, 18'd3, 18'd20};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] trig = '0;
  logic         busy;
  logic [1:0]   active_id;
  int           n_vec = 0;
  int           n_err = 0;

  sfx_scheduler_if #(.AW(AW)) bus ();

`ifdef SFX_SCHED_ATTEN_EN
  logic [1:0]  vol = 2'd0;
  logic        use_ovr = 1'b0;
  logic [23:0] rom_ovr = '0;
  assign bus.rom_q = use_ovr ? rom_ovr : {6'd0, bus.rom_addr};
`else
  assign bus.rom_q = {6'd0, bus.rom_addr};
`endif

  sfx_scheduler #(.N(N), .AW(AW), .BASE(BASE), .LEN(LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig),
`ifdef SFX_SCHED_ATTEN_EN
    .vol       (vol),
`endif
    .bus       (bus.master),
    .busy      (busy),
    .active_id (active_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  trig;
    logic        rdy;
    logic        busy;
    logic [1:0]  id;
    logic [17:0] addr;
    logic        wr;
    logic [23:0] d;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic rst, input logic [3:0] tr, input logic rdy, input logic b,
                      input logic [1:0] id, input logic [17:0] addr, input logic wr,
                      input logic [23:0] d);
    vec_t v;
    v.rst = rst; v.trig = tr; v.rdy = rdy; v.busy = b; v.id = id; v.addr = addr; v.wr = wr; v.d = d;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic [3:0] tr, input logic rdy);
    @(negedge clk);
    reset = rst;
    trig = tr;
    bus.aud_write_ready = rdy;
    #1;
  endtask

  logic [23:0] wlog[$];

  initial begin
    bus.aud_write_ready = 1'b1;
    //     rst trig     rdy  busy id  addr      wr  d
    addv(0, 4'b0000, 1, 0, 2'd0, 18'd0,    1, 24'd0);
    addv(1, 4'b0000, 1, 0, 2'd0, 18'd0,    1, 24'd0);
    addv(1, 4'b0000, 1, 0, 2'd0, 18'd0,    1, 24'd0);
    addv(1, 4'b0010, 1, 0, 2'd0, 18'd0,    1, 24'd0);
    addv(1, 4'b0000, 1, 1, 2'd1, 18'd100,  0, 24'd0);
    addv(1, 4'b0000, 1, 1, 2'd1, 18'd100,  1, 24'd100);
    addv(1, 4'b0000, 1, 1, 2'd1, 18'd101,  0, 24'd100);
    addv(1, 4'b0000, 1, 1, 2'd1, 18'd101,  1, 24'd101);
    addv(1, 4'b0000, 1, 1, 2'd1, 18'd102,  0, 24'd101);
    addv(1, 4'b0000, 1, 1, 2'd1, 18'd102,  1, 24'd102);
    addv(1, 4'b0000, 1, 0, 2'd1, 18'd102,  1, 24'd0);
    addv(1, 4'b0101, 1, 0, 2'd1, 18'd102,  1, 24'd0);
    addv(1, 4'b0000, 1, 1, 2'd2, 18'd200,  0, 24'd0);
    addv(1, 4'b0001, 1, 1, 2'd2, 18'd200,  1, 24'd200);
    addv(1, 4'b0001, 1, 1, 2'd2, 18'd201,  0, 24'd200);
    addv(1, 4'b0000, 1, 1, 2'd2, 18'd201,  1, 24'd201);
    addv(1, 4'b0000, 1, 1, 2'd2, 18'd202,  0, 24'd201);
    addv(1, 4'b1000, 1, 1, 2'd2, 18'd202,  1, 24'd202);
    addv(1, 4'b0000, 1, 1, 2'd3, 18'd1000, 0, 24'd202);
    addv(1, 4'b0000, 0, 1, 2'd3, 18'd1000, 0, 24'd1000);
    addv(1, 4'b0000, 1, 1, 2'd3, 18'd1000, 1, 24'd1000);
    addv(1, 4'b0000, 1, 1, 2'd3, 18'd1001, 0, 24'd1000);
    addv(1, 4'b0000, 1, 1, 2'd3, 18'd1001, 1, 24'd1001);
    addv(1, 4'b0000, 1, 1, 2'd3, 18'd1002, 0, 24'd1001);
    addv(1, 4'b0000, 1, 1, 2'd3, 18'd1002, 1, 24'd1002);
    addv(1, 4'b0000, 1, 1, 2'd3, 18'd1003, 0, 24'd1002);
    addv(1, 4'b0000, 1, 1, 2'd3, 18'd1003, 1, 24'd1003);
    addv(1, 4'b0000, 1, 0, 2'd3, 18'd1003, 1, 24'd0);
    addv(1, 4'b0001, 1, 0, 2'd3, 18'd1003, 1, 24'd0);
    addv(1, 4'b0000, 1, 1, 2'd0, 18'd0,    0, 24'd0);
    addv(1, 4'b0000, 1, 1, 2'd0, 18'd0,    1, 24'd0);
    addv(1, 4'b0000, 1, 1, 2'd0, 18'd1,    0, 24'd0);
    addv(0, 4'b1000, 1, 0, 2'd0, 18'd0,    1, 24'd0);
    addv(1, 4'b0000, 1, 0, 2'd0, 18'd0,    1, 24'd0);
    addv(1, 4'b0000, 0, 0, 2'd0, 18'd0,    0, 24'd0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].trig, vecs[i].rdy);
      cmp($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      cmp($sformatf("v%0d.id", i),   32'(active_id), 32'(vecs[i].id));
      cmp($sformatf("v%0d.addr", i), 32'(bus.rom_addr), 32'(vecs[i].addr));
      cmp($sformatf("v%0d.wr", i),   32'(bus.aud_write), 32'(vecs[i].wr));
      cmp($sformatf("v%0d.d", i),    32'(bus.aud_write_d), 32'(vecs[i].d));
    end

    // Ready held low for five cycles in S_OUT.
    cyc(1, 4'b0010, 1);
    cyc(1, 4'b0000, 0);
    cmp("stall.fetch_addr", 32'(bus.rom_addr), 32'd100);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 4'b0000, 0);
      cmp($sformatf("stall%0d.wr", k), 32'(bus.aud_write), 32'd0);
      cmp($sformatf("stall%0d.d", k), 32'(bus.aud_write_d), 32'd100);
    end
    cyc(1, 4'b0000, 1);
    cmp("stall.release_wr", 32'(bus.aud_write), 32'd1);
    cyc(1, 4'b0000, 1);
    cmp("stall.next_addr", 32'(bus.rom_addr), 32'd101);
    cmp("stall.next_wr", 32'(bus.aud_write), 32'd0);
    for (int k = 0; k < 6; k++) cyc(1, 4'b0000, 1);
    cmp("stall.done_busy", 32'(busy), 32'd0);

    // Effect 0 preempted by effect 3 while holding offset 10.
    cyc(1, 4'b0001, 1);
    for (int k = 1; k <= 21; k++) cyc(1, 4'b0000, 1);
    cmp("pre.addr10", 32'(bus.rom_addr), 32'd10);
    cyc(1, 4'b1000, 0);
    cmp("pre.hold_wr", 32'(bus.aud_write), 32'd0);
    cmp("pre.hold_d", 32'(bus.aud_write_d), 32'd10);
    cyc(1, 4'b0000, 1);
    cmp("pre.id", 32'(active_id), 32'd3);
    cmp("pre.addr", 32'(bus.rom_addr), 32'd1000);
    cmp("pre.fetch_wr", 32'(bus.aud_write), 32'd0);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 4'b0000, 1);
      if (busy && bus.aud_write) wlog.push_back(bus.aud_write_d);
    end
    cmp("pre.nwrites", 32'(wlog.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wlog.size()) cmp($sformatf("pre.w%0d", k), 32'(wlog[k]), 32'(1000 + k));
    end
    cmp("pre.done_busy", 32'(busy), 32'd0);

`ifdef SFX_SCHED_ATTEN_EN
    use_ovr = 1'b1;
    rom_ovr = 24'hFFFF00;
    vol = 2'd2;
    cyc(1, 4'b0001, 1);
    cyc(1, 4'b0000, 0);
    cyc(1, 4'b0000, 0);
    cmp("atten.neg", 32'(bus.aud_write_d), 32'h00FFFFC0);
    rom_ovr = 24'h000100;
    vol = 2'd3;
    cyc(1, 4'b0000, 1);
    cyc(1, 4'b0000, 0);
    cyc(1, 4'b0000, 0);
    cmp("atten.pos", 32'(bus.aud_write_d), 32'h00000020);
    cyc(0, 4'b0000, 1);
    cmp("atten.reset_d", 32'(bus.aud_write_d), 32'd0);
    use_ovr = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
